// File: rtl/fetch_unit_if.sv
// Bundle between fetch_unit and its environment: instruction-memory request
// port, redirect input and the decode-side instruction stream.
interface fetch_unit_if;
  // imem: a request is held (req high, addr stable) until the cycle ack is high,
  // and rdata is valid in that cycle. Decode: the head moves only in a cycle where
  // instr_valid_o and instr_ready_i are both high; valid never depends on ready.
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        misalign_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output instr_o, pc_o, pc_plus4_o, instr_valid_o,
    input  instr_ready_i,
    output misalign_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  instr_o, pc_o, pc_plus4_o, instr_valid_o,
    output instr_ready_i,
    input  misalign_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, {pc,instr} FIFO.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect pulse).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        bus,
  output logic [1:0]          dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   req_addr, req_addr_n;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic          req, push, pop, full, valid;
  logic [31:0]   addr;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign addr  = (state == IDLE) ? fetch_pc : req_addr;
  assign pop   = valid && bus.instr_ready_i && !bus.redirect_i;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    req        = 1'b1;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        req = !full;
        if (req) begin
          fetch_pc_n = fetch_pc + 32'd4;
          if (bus.imem_ack_i) begin
            push = !bus.redirect_i;
          end else begin
            req_addr_n = fetch_pc;
            state_n    = bus.redirect_i ? DISCARD : BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.imem_ack_i) begin
          push    = !bus.redirect_i;
          state_n = IDLE;
        end else if (bus.redirect_i) begin
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.imem_ack_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Redirect overrides any sequential advance made above.
    if (bus.redirect_i) fetch_pc_n = {bus.redirect_pc_i[31:2], 2'b00};
  end

  always_comb begin
    count_n = count;
    if (bus.redirect_i) count_n = '0;
    else                count_n = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
      count    <= count_n;
      if (bus.redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]    <= addr;
          fifo_instr[wr_ptr] <= bus.imem_rdata_i;
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Request is gated by rst_n so nothing is issued while reset is asserted.
  assign bus.imem_req_o    = req && rst_n;
  assign bus.imem_addr_o   = addr;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = fifo_instr[rd_ptr];
  assign bus.pc_o          = fifo_pc[rd_ptr];
  assign bus.pc_plus4_o    = fifo_pc[rd_ptr] + 32'd4;
  assign dbg_state         = state;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
  end
  assign bus.misalign_o = misalign_q;
`else
  assign bus.misalign_o = 1'b0;
`endif
endmodule
